// File: rtl/decode_pkg.sv
// Shared constants, types and the instruction decoder for the decode/issue stage.
// Optional build macro DECODE_WB_BYPASS_EN is consumed by decode_scoreboard.
package decode_pkg;

  localparam int INSTR_W = 24;
  localparam int REG_AW  = 5;
  localparam int DATA_W  = 4;
  localparam int NREGS   = 1 << REG_AW;

  localparam logic [3:0] OP_STORE  = 4'hC;
  localparam logic [3:0] OP_BRANCH = 4'hD;
  localparam logic [3:0] OP_NOP    = 4'hE;
  localparam logic [3:0] OP_HALT   = 4'hF;

  localparam int OPC_LO = 20;
  localparam int RD_LO  = 15;
  localparam int RS1_LO = 10;
  localparam int RS2_LO = 5;
  localparam int IMM_LO = 0;

  typedef enum logic [1:0] {ST_EMPTY, ST_FULL, ST_HALTED} state_e;

  typedef struct packed {
    logic [3:0]        opcode;
    logic [REG_AW-1:0] rs1;
    logic [REG_AW-1:0] rs2;
    logic [REG_AW-1:0] rd;
    logic              use1;
    logic              use2;
    logic              we;
    logic [DATA_W-1:0] imm;
  } dec_t;

  // Unused address fields are forced to zero so downstream never sees stale bits.
  function automatic dec_t decode(input logic [INSTR_W-1:0] ins);
    dec_t d;
    d        = '0;
    d.opcode = ins[OPC_LO +: 4];
    d.imm    = ins[IMM_LO +: DATA_W];
    if (!d.opcode[3]) begin
      d.use1 = 1'b1; d.use2 = 1'b1; d.we = 1'b1;
    end else if (d.opcode[3:2] == 2'b10) begin
      d.use1 = 1'b1; d.we = 1'b1;
    end else if (d.opcode == OP_STORE || d.opcode == OP_BRANCH) begin
      d.use1 = 1'b1; d.use2 = 1'b1;
    end
    d.rs1 = d.use1 ? ins[RS1_LO +: REG_AW] : '0;
    d.rs2 = d.use2 ? ins[RS2_LO +: REG_AW] : '0;
    d.rd  = d.we   ? ins[RD_LO  +: REG_AW] : '0;
    return d;
  endfunction

endpackage

// File: rtl/decode_scoreboard.sv
// In-flight destination tracker with hazard lookup for two sources and one destination.
// DECODE_WB_BYPASS_EN: lookups see the current-cycle writeback as already cleared.
module decode_scoreboard
  import decode_pkg::*;
(
  input  logic              clock,
  input  logic              reset_n,
  input  logic              set_en,
  input  logic [REG_AW-1:0] set_reg,
  input  logic              clr_en,
  input  logic [REG_AW-1:0] clr_reg,
  input  logic [REG_AW-1:0] rs1,
  input  logic              use1,
  input  logic [REG_AW-1:0] rs2,
  input  logic              use2,
  input  logic [REG_AW-1:0] rd,
  input  logic              use_rd,
  output logic              hazard
);

  logic [NREGS-1:0] sb_q, sb_d, set_mask, clr_mask, view;

  always_comb begin
    set_mask = set_en ? (NREGS'(1) << set_reg) : '0;
    clr_mask = clr_en ? (NREGS'(1) << clr_reg) : '0;
    // Set is applied after clear so a same-cycle set/clear of one bit leaves it set.
    sb_d     = (sb_q & ~clr_mask) | set_mask;
`ifdef DECODE_WB_BYPASS_EN
    view     = sb_q & ~clr_mask;
`else
    view     = sb_q;
`endif
    hazard   = (use1 & view[rs1]) | (use2 & view[rs2]) | (use_rd & view[rd]);
  end

  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) sb_q <= '0;
    else          sb_q <= sb_d;
  end

endmodule

// File: rtl/decode_issue.sv
// Decode/issue stage: one-entry instruction buffer, EMPTY/FULL/HALTED FSM, RAW/WAW stall.
// Build option DECODE_WB_BYPASS_EN enables same-cycle writeback bypass in the scoreboard.
module decode_issue
  import decode_pkg::*;
(
  input  logic               clock,
  input  logic               reset_n,
  input  logic               in_valid,
  output logic               in_ready,
  input  logic [INSTR_W-1:0] in_instr,
  output logic               out_valid,
  input  logic               out_ready,
  output logic [3:0]         out_opcode,
  output logic [REG_AW-1:0]  read_register1,
  output logic [REG_AW-1:0]  read_register2,
  output logic [REG_AW-1:0]  write_register,
  output logic               reg_write,
  output logic [DATA_W-1:0]  out_imm,
  input  logic               wb_valid,
  input  logic [REG_AW-1:0]  wb_reg,
  output logic               halted
);

  state_e state_q;
  dec_t   dec_q, dec_in;
  logic   hazard, issue, is_halt;

  assign dec_in = decode(in_instr);

  decode_scoreboard u_sb (
    .clock   (clock),
    .reset_n (reset_n),
    .set_en  (issue & dec_q.we),
    .set_reg (dec_q.rd),
    .clr_en  (wb_valid),
    .clr_reg (wb_reg),
    .rs1     (dec_q.rs1),
    .use1    (dec_q.use1),
    .rs2     (dec_q.rs2),
    .use2    (dec_q.use2),
    .rd      (dec_q.rd),
    .use_rd  (dec_q.we),
    .hazard  (hazard)
  );

  assign is_halt   = (dec_q.opcode == OP_HALT);
  assign out_valid = (state_q == ST_FULL) && !hazard;
  assign issue     = out_valid && out_ready;
  // HALT issue must not accept a follower that would then be silently dropped.
  assign in_ready  = (state_q == ST_EMPTY) || (issue && !is_halt);
  assign halted    = (state_q == ST_HALTED);

  assign out_opcode     = dec_q.opcode;
  assign read_register1 = dec_q.rs1;
  assign read_register2 = dec_q.rs2;
  assign write_register = dec_q.rd;
  assign reg_write      = dec_q.we;
  assign out_imm        = dec_q.imm;

  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) begin
      state_q <= ST_EMPTY;
      dec_q   <= '0;
    end else begin
      case (state_q)
        ST_EMPTY: if (in_valid) begin
          dec_q   <= dec_in;
          state_q <= ST_FULL;
        end
        ST_FULL: if (issue) begin
          if (is_halt)       state_q <= ST_HALTED;
          else if (in_valid) dec_q   <= dec_in;
          else               state_q <= ST_EMPTY;
        end
        default: state_q <= ST_HALTED;
      endcase
    end
  end

endmodule
